daq_tx_arbiter: RTL

- Round-robin arbiter and sequencer that shares the single optical-link frame processor between NREQ packet sources (DCFEB/ALCT/TMB-style FIFOs).
- Grants one source, holds VALID to the frame processor through preamble and TX_ACK, then streams the granted source's words.
- Ends the packet by dropping VALID, waits for the frame processor to return to Idle, applies an inter-packet gap, then re-arbitrates.

---
 rtl/daq_tx_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/daq_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : daq_tx_arbiter
// Description : Round-robin arbiter and sequencer sharing one optical-link
//               frame processor between NREQ packet sources. Grants a source,
//               holds VALID through preamble/TX_ACK, streams the source words,
//               waits for the frame processor to go Idle, then applies an
//               inter-packet gap before re-arbitrating.
// Revision    : 1.0 - initial release
// ============================================================================
module daq_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int DW          = 16,
    parameter int MAX_WORDS   = 4096,
    parameter int ACK_TIMEOUT = 64,
    parameter int GAP_CYCLES  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] src_data,
    input  logic [NREQ-1:0]    src_last,
    output logic [NREQ-1:0]    src_rd,
    output logic [NREQ-1:0]    grant,
    output logic               tx_valid,
    output logic [DW-1:0]      tx_data,
    input  logic               tx_ack,
    input  logic [2:0]         frm_state,
    output logic               busy,
    output logic               err,
    output logic [15:0]        pkt_cnt
);

    localparam int c_pw  = $clog2(NREQ);
    localparam int c_wcw = $clog2(MAX_WORDS + 1);
    localparam int c_acw = $clog2(ACK_TIMEOUT + 1);
    localparam int c_gcw = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [NREQ-1:0] c_one = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ_TX    = 3'd1,
        ST_STREAM    = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    state_t             r_state;
    logic [NREQ-1:0]    r_grant;
    logic               r_tx_valid;
    logic               r_err_to;
    logic               r_timed_out;
    logic [15:0]        r_pkt_cnt;
    logic [c_wcw-1:0]   r_word_cnt;
    logic [c_acw-1:0]   r_ack_cnt;
    logic [c_gcw-1:0]   r_gap_cnt;
    logic [c_pw-1:0]    r_ptr;

    logic               w_win_found;
    logic [c_pw-1:0]    w_win_idx;
    int                 w_cand;
    logic [DW-1:0]      w_cur_data;
    logic               w_cur_last;
    logic               w_at_max;
    logic               w_final;
    logic               w_overrun;
    logic               w_streaming;

    // Round-robin search: first requester strictly after the pointer, wrapping.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = (int'(r_ptr) + k) % NREQ;
            if (!w_win_found && req[w_cand[c_pw-1:0]]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand[c_pw-1:0];
            end
        end
    end

    // The pointer always holds the granted index while a packet is in flight.
    assign w_cur_data  = src_data[int'(r_ptr)*DW +: DW];
    assign w_cur_last  = src_last[r_ptr];
    assign w_streaming = (r_state == ST_STREAM);
    assign w_at_max    = (r_word_cnt == c_wcw'(MAX_WORDS - 1));
    assign w_final     = w_cur_last || w_at_max;
    assign w_overrun   = w_streaming && w_at_max && !w_cur_last;

    assign src_rd   = w_streaming ? r_grant : '0;
    assign tx_data  = w_streaming ? w_cur_data : '0;
    assign grant    = r_grant;
    assign tx_valid = r_tx_valid;
    assign busy     = (r_state != ST_IDLE);
    // Timeout error is registered; overrun error flags the MAX_WORDSth word itself.
    assign err      = r_err_to | w_overrun;
    assign pkt_cnt  = r_pkt_cnt;

    // Packet sequencer: arbitrate, request link, stream, drain, gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_tx_valid  <= 1'b0;
            r_err_to    <= 1'b0;
            r_timed_out <= 1'b0;
            r_pkt_cnt   <= '0;
            r_word_cnt  <= '0;
            r_ack_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_ptr       <= c_pw'(NREQ - 1);
        end else begin
            r_err_to <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_win_found && (frm_state == 3'b000)) begin
                        r_grant    <= c_one << w_win_idx;
                        r_ptr      <= w_win_idx;
                        r_tx_valid <= 1'b1;
                        r_ack_cnt  <= '0;
                        r_state    <= ST_REQ_TX;
                    end
                end
                ST_REQ_TX: begin
                    if (tx_ack) begin
                        r_state <= ST_STREAM;
                    end else if (r_ack_cnt == c_acw'(ACK_TIMEOUT - 1)) begin
                        r_err_to    <= 1'b1;
                        r_timed_out <= 1'b1;
                        r_tx_valid  <= 1'b0;
                        r_state     <= ST_WAIT_DONE;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + 1'b1;
                    end
                end
                ST_STREAM: begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                    if (w_final) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (frm_state == 3'b000) begin
                        r_grant     <= '0;
                        r_word_cnt  <= '0;
                        r_gap_cnt   <= '0;
                        r_timed_out <= 1'b0;
                        if (!r_timed_out) begin
                            r_pkt_cnt <= r_pkt_cnt + 16'd1;
                        end
                        r_state <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == c_gcw'(GAP_CYCLES - 1)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
